lfsr_galois_mstep: RTL and testbench

LFSR_GALOIS_MSTEP -- requirements
Module: lfsr_galois_mstep

---
 rtl/lfsr_galois_mstep.sv | 100 ++++++++++
 tb/tb_lfsr_galois_mstep.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_galois_mstep.sv
// Galois LFSR advancing STEP steps per enabled cycle, with seed tracking,
// period measurement on wrap and optional recovery from the all-zero lockup state.
module lfsr_galois_mstep #(
   parameter int              WIDTH  = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'hB400,
   parameter int              STEP   = 1,
   parameter                  DIR    = "LSB",
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
   parameter bit              RESEED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [WIDTH-1:0] lfsr_in,
   input  logic             shift_en,
   input  logic [STEP-1:0]  din,
   output logic [WIDTH-1:0] lfsr_out,
   output logic [STEP-1:0]  dout,
   output logic             lockup,
   output logic             wrap,
   output logic [WIDTH-1:0] period
);

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   localparam bit               MSB_FIRST = (DIR == "MSB");
   localparam logic [WIDTH-1:0] POLY_REV  = bitrev(POLY);

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH-1:0] cnt_inc;
   logic [STEP-1:0]  fb_bits;
   logic             fb;
   logic             reseed_hit;
   logic             wrap_hit;

   // Chain STEP single steps within the cycle; step i consumes din[i].
   always_comb begin
      next_state = state;
      fb_bits    = '0;
      fb         = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         if (MSB_FIRST) begin
            fb         = next_state[WIDTH-1] ^ din[i];
            next_state = {next_state[WIDTH-2:0], 1'b0} ^ (fb ? POLY_REV : '0);
         end else begin
            fb         = next_state[0] ^ din[i];
            next_state = (next_state >> 1) ^ (fb ? POLY : '0);
         end
         fb_bits[i] = fb;
      end
   end

   // A zero seed can never count as a wrap target.
   assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
   assign reseed_hit = RESEED && shift_en && (state == '0) && (din == '0);
   assign wrap_hit   = (next_state == seed_q) && (seed_q != '0);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= SEED;
         seed_q <= SEED;
         cnt    <= '0;
         period <= '0;
         dout   <= '0;
         wrap   <= 1'b0;
      end else if (load) begin
         state  <= lfsr_in;
         seed_q <= lfsr_in;
         cnt    <= '0;
         wrap   <= 1'b0;
      end else if (reseed_hit) begin
         state <= SEED;
         wrap  <= 1'b0;
      end else if (shift_en) begin
         state <= next_state;
         dout  <= fb_bits;
         if (wrap_hit) begin
            wrap   <= 1'b1;
            period <= cnt_inc;
            cnt    <= '0;
         end else begin
            wrap <= 1'b0;
            cnt  <= cnt_inc;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

   assign lfsr_out = state;
   assign lockup   = (state == '0);

endmodule

// File: tb/tb_lfsr_galois_mstep.sv
// Scoreboarded bench: three LFSR configurations driven together, checked against
// a mirrored-arithmetic reference model plus directed known-answer checks.
module tb_lfsr_galois_mstep;

   localparam logic [15:0] POLY = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct packed {
      logic [15:0] st;
      logic [1:0]  dout;
      logic        lockup;
      logic        wrap;
      logic [15:0] period;
   } obs_t;
   typedef obs_t [2:0] trio_t;

   logic        clk;
   logic        rst_b;
   logic        load;
   logic [15:0] lfsr_in;
   logic        shift_en;
   logic [1:0]  din;

   logic [15:0] out_a, out_b, out_c, per_a, per_b, per_c;
   logic [0:0]  dout_a, dout_b;
   logic [1:0]  dout_c;
   logic        lockup_a, lockup_b, lockup_c, wrap_a, wrap_b, wrap_c;

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_state[3];
   logic [15:0] m_seed[3];
   logic [15:0] m_cnt[3];
   logic [15:0] m_period[3];
   logic [1:0]  m_dout[3];
   logic        m_wrap[3];
   trio_t       expq[$];

   // a: STEP=1 LSB reseed, b: STEP=1 MSB no reseed, c: STEP=2 LSB reseed
   lfsr_galois_mstep #(.WIDTH(16), .POLY(POLY), .STEP(1), .DIR("LSB"), .SEED(SEED), .RESEED(1'b1)) dut_a (
      .clk(clk), .rst_b(rst_b), .load(load), .lfsr_in(lfsr_in), .shift_en(shift_en), .din(din[0:0]),
      .lfsr_out(out_a), .dout(dout_a), .lockup(lockup_a), .wrap(wrap_a), .period(per_a));

   lfsr_galois_mstep #(.WIDTH(16), .POLY(POLY), .STEP(1), .DIR("MSB"), .SEED(SEED), .RESEED(1'b0)) dut_b (
      .clk(clk), .rst_b(rst_b), .load(load), .lfsr_in(lfsr_in), .shift_en(shift_en), .din(din[1:1]),
      .lfsr_out(out_b), .dout(dout_b), .lockup(lockup_b), .wrap(wrap_b), .period(per_b));

   lfsr_galois_mstep #(.WIDTH(16), .POLY(POLY), .STEP(2), .DIR("LSB"), .SEED(SEED), .RESEED(1'b1)) dut_c (
      .clk(clk), .rst_b(rst_b), .load(load), .lfsr_in(lfsr_in), .shift_en(shift_en), .din(din),
      .lfsr_out(out_c), .dout(dout_c), .lockup(lockup_c), .wrap(wrap_c), .period(per_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

   function automatic int stepOf(input int k);
      return (k == 2) ? 2 : 1;
   endfunction

   function automatic logic [1:0] dinOf(input int k, input logic [1:0] d);
      if (k == 0) return {1'b0, d[0]};
      if (k == 1) return {1'b0, d[1]};
      return d;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // MSB-first operation is the LSB recurrence seen through a bit-reversal mirror.
   task automatic modelCycle(input int k, input logic ld, input logic [15:0] lin,
                             input logic sh, input logic [1:0] d);
      logic [15:0] s;
      logic [1:0]  fbs;
      logic        fb;
      logic [15:0] nxt;
      logic [15:0] inc;
      inc = (m_cnt[k] == 16'hFFFF) ? 16'hFFFF : m_cnt[k] + 16'd1;
      if (ld) begin
         m_state[k] = lin;
         m_seed[k]  = lin;
         m_cnt[k]   = 16'd0;
         m_wrap[k]  = 1'b0;
      end else if (sh && k != 1 && m_state[k] == 16'd0 && d == 2'd0) begin
         m_state[k] = SEED;
         m_wrap[k]  = 1'b0;
      end else if (sh) begin
         s   = (k == 1) ? rev16(m_state[k]) : m_state[k];
         fbs = 2'b00;
         for (int i = 0; i < stepOf(k); i++) begin
            fb     = s[0] ^ d[i];
            s      = (s >> 1) ^ (fb ? POLY : 16'h0000);
            fbs[i] = fb;
         end
         nxt       = (k == 1) ? rev16(s) : s;
         m_dout[k] = fbs;
         if (nxt == m_seed[k] && m_seed[k] != 16'd0) begin
            m_wrap[k]   = 1'b1;
            m_period[k] = inc;
            m_cnt[k]    = 16'd0;
         end else begin
            m_wrap[k] = 1'b0;
            m_cnt[k]  = inc;
         end
         m_state[k] = nxt;
      end else begin
         m_wrap[k] = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [15:0] lin, input logic sh, input logic [1:0] d);
      trio_t e;
      @(negedge clk);
      load     = ld;
      lfsr_in  = lin;
      shift_en = sh;
      din      = d;
      for (int k = 0; k < 3; k++) begin
         modelCycle(k, ld, lin, sh, dinOf(k, d));
         e[k].st     = m_state[k];
         e[k].dout   = m_dout[k];
         e[k].lockup = (m_state[k] == 16'd0);
         e[k].wrap   = m_wrap[k];
         e[k].period = m_period[k];
      end
      expq.push_back(e);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_out_a"}, out_a, SEED);
      checkOutput({tag, "_out_b"}, out_b, SEED);
      checkOutput({tag, "_out_c"}, out_c, SEED);
      checkOutput({tag, "_dout"}, {13'd0, dout_c, dout_b, dout_a}, 16'd0);
      checkOutput({tag, "_per"}, per_a | per_b | per_c, 16'd0);
      checkOutput({tag, "_flags"}, {10'd0, lockup_a, lockup_b, lockup_c, wrap_a, wrap_b, wrap_c}, 16'd0);
   endtask

   // Reset lands between clock edges; outputs must settle with no edge.
   task automatic doReset(input string tag);
      @(negedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         m_state[k] = SEED; m_seed[k] = SEED; m_cnt[k] = 16'd0;
         m_period[k] = 16'd0; m_dout[k] = 2'd0; m_wrap[k] = 1'b0;
      end
      checkReset(tag);
      @(negedge clk);
      load     = 1'b0;
      shift_en = 1'b0;
      rst_b    = 1'b1;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      trio_t e;
      trio_t a;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a[0] = '{out_a, {1'b0, dout_a}, lockup_a, wrap_a, per_a};
            a[1] = '{out_b, {1'b0, dout_b}, lockup_b, wrap_b, per_b};
            a[2] = '{out_c, dout_c, lockup_c, wrap_c, per_c};
            for (int k = 0; k < 3; k++) begin
               checkOutput($sformatf("sb%0d_state", k), a[k].st, e[k].st);
               checkOutput($sformatf("sb%0d_dout", k), {14'd0, a[k].dout}, {14'd0, e[k].dout});
               checkOutput($sformatf("sb%0d_lockup", k), {15'd0, a[k].lockup}, {15'd0, e[k].lockup});
               checkOutput($sformatf("sb%0d_wrap", k), {15'd0, a[k].wrap}, {15'd0, e[k].wrap});
               checkOutput($sformatf("sb%0d_period", k), a[k].period, e[k].period);
            end
         end
      end
   end

   initial begin : watchdog
      #1500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      rst_b    = 1'b1;
      load     = 1'b0;
      lfsr_in  = 16'd0;
      shift_en = 1'b0;
      din      = 2'd0;
      #1;
      doReset("reset0");

      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("kat_a1", out_a, 16'hE270);
      checkOutput("kat_a1_dout", {15'd0, dout_a}, 16'd1);
      checkOutput("kat_c1", out_c, 16'h7138);
      checkOutput("kat_c1_dout", {14'd0, dout_c}, 16'd1);
      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("kat_a2", out_a, 16'h7138);
      checkOutput("kat_a2_dout", {15'd0, dout_a}, 16'd0);

      applyStimulus(1'b1, 16'h0000, 1'b0, 2'd0);
      settle();
      checkOutput("zero_lockup", {14'd0, lockup_a, lockup_b}, 16'd3);
      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("reseed_a", out_a, SEED);
      checkOutput("reseed_flags", {14'd0, lockup_a, wrap_a}, 16'd0);
      checkOutput("noreseed_b", out_b, 16'h0000);

      applyStimulus(1'b1, 16'h1234, 1'b1, 2'd0);
      settle();
      checkOutput("load_over_shift_a", out_a, 16'h1234);
      checkOutput("load_over_shift_b", out_b, 16'h1234);
      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("msb_shift_b", out_b, 16'h2468);

      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom % 10) == 0,
                       (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom),
                       ($urandom % 4) != 0,
                       (($urandom % 3) == 0) ? 2'($urandom) : 2'd0);
      end
      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      doReset("reset_mid");

      for (int n = 0; n < 65535; n++) applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("wrap_state_a", out_a, SEED);
      checkOutput("wrap_period_a", per_a, 16'd65535);
      checkOutput("wrap_period_bc", per_b & per_c, 16'd65535);
      checkOutput("wrap_pulse", {13'd0, wrap_a, wrap_b, wrap_c}, 16'd7);
      applyStimulus(1'b0, 16'd0, 1'b1, 2'd0);
      settle();
      checkOutput("wrap_one_cycle", {13'd0, wrap_a, wrap_b, wrap_c}, 16'd0);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
